memory_round_ctrl: RTL

Round sequencer for the memory game. Generates a 10-bit pattern per round, writes it into the 16-entry pattern memory, and shows it on the LEDs for a fixed time. It then blanks the LEDs, waits for the player's switch guess and submit key, and scores the guess. It drives the memory port (`wn`/`we`/`d`) plus the `led`, `display_state`, `correct`, `incorrect` and `percent` signals consumed by the HEX display logic.

---
 rtl/memory_game_pkg.sv | 25 ++
 rtl/memory_percent_div.sv | 55 +++++
 rtl/memory_round_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game round sequencer.
// State codes double as the HEX display state number.
package memory_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_BLANK = 3'd4,
    ST_WAIT  = 3'd5,
    ST_CHECK = 3'd6,
    ST_OVER  = 3'd7
  } state_t;

  localparam int NUM_ROUNDS = 16;
  localparam int PAT_W = 10;

  localparam logic [PAT_W-1:0] LFSR_SEED = 10'h001;
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;

  localparam logic [2:0] CHECK_LAST = 3'd7;

endpackage

// File: rtl/memory_percent_div.sv
// Restoring divider: 7 quotient bits over 7 clocks after start.
// Quotient is presented alongside the done pulse.
module memory_percent_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] dividend,
  input  logic [4:0]  divisor,
  output logic [6:0]  quotient,
  output logic        done
);

  logic       busy;
  logic [2:0] cnt;
  logic [4:0] rem;
  logic [4:0] dvs;
  logic [6:0] low;
  logic [5:0] q;
  logic [5:0] trial;
  logic [4:0] diff;
  logic       ge;

  assign trial = {rem, low[6]};
  assign ge    = trial >= {1'b0, dvs};
  assign diff  = trial[4:0] - dvs;
  assign done  = busy && (cnt == 3'd6);

  // Divide by zero would set every bit, so force it to zero.
  assign quotient = (dvs == '0) ? '0 : {q, ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dvs  <= '0;
      low  <= '0;
      q    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= {1'b0, dividend[10:7]};
      dvs  <= divisor;
      low  <= dividend[6:0];
      q    <= '0;
    end else if (busy) begin
      rem  <= ge ? diff : trial[4:0];
      low  <= {low[5:0], 1'b0};
      q    <= {q[4:0], ge};
      cnt  <= cnt + 3'd1;
      if (cnt == 3'd6) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_round_ctrl.sv
// Memory game round sequencer: pattern generation, display,
// guess capture and scoring with running percentage.
module memory_round_ctrl
  import memory_game_pkg::*;
#(
  parameter int SHOW_CYCLES  = 100_000_000,
  parameter int BLANK_CYCLES = 25_000_000
) (
  input  logic             clock_50M,
  input  logic             resetn,
  input  logic [PAT_W-1:0] sw,
  input  logic             key_start_n,
  input  logic             key_submit_n,
  input  logic [PAT_W-1:0] mem_rdata,
  output logic [3:0]       wn,
  output logic             we,
  output logic [PAT_W-1:0] d,
  output logic [PAT_W-1:0] led,
  output logic [2:0]       display_state,
  output logic [6:0]       correct,
  output logic [6:0]       incorrect,
  output logic [6:0]       percent
);

  state_t state, state_nx;

  logic [PAT_W-1:0] lfsr;
  logic [PAT_W-1:0] sw_s1, sw_s2;
  logic [2:0]       st_sync, sb_sync;
  logic             start_ev, submit_ev;
  logic [31:0]      tmr;
  logic [3:0]       round;
  logic [PAT_W-1:0] pattern, guess;
  logic             hit;
  logic [4:0]       corr_nx, tot_nx;
  logic [10:0]      dividend;
  logic             div_start, div_done;
  logic [6:0]       div_q;
  logic             check_end;

  // Bit 0 is the first sync flop; an event is 1 -> 0 between flops 2 and 3.
  assign start_ev  = st_sync[2] & ~st_sync[1];
  assign submit_ev = sb_sync[2] & ~sb_sync[1];

  assign hit       = (guess == pattern);
  assign corr_nx   = correct[4:0] + {4'd0, hit};
  assign tot_nx    = correct[4:0] + incorrect[4:0] + 5'd1;
  assign dividend  = {6'd0, corr_nx} * 11'd100;
  assign div_start = (state == ST_CHECK) && (tmr == 32'd0);
  assign check_end = (state == ST_CHECK) && (tmr == 32'(CHECK_LAST));

  assign wn            = round;
  assign we            = (state == ST_WRITE);
  assign d             = (state == ST_WRITE) ? lfsr : '0;
  assign led           = (state == ST_SHOW) ? pattern : '0;
  assign display_state = state;

  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start_ev) state_nx = ST_WRITE;
      ST_WRITE: state_nx = ST_READ;
      ST_READ:  state_nx = ST_SHOW;
      ST_SHOW:
        if (tmr == 32'(SHOW_CYCLES - 1))
          state_nx = ST_BLANK;
      ST_BLANK:
        if (tmr == 32'(BLANK_CYCLES - 1))
          state_nx = ST_WAIT;
      ST_WAIT:  if (submit_ev) state_nx = ST_CHECK;
      ST_CHECK:
        if (check_end)
          state_nx = (round == 4'(NUM_ROUNDS - 1))
                   ? ST_OVER : ST_WRITE;
      ST_OVER:  if (start_ev) state_nx = ST_WRITE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) begin
      lfsr      <= LFSR_SEED;
      sw_s1     <= '1;
      sw_s2     <= '1;
      st_sync   <= '1;
      sb_sync   <= '1;
      tmr       <= '0;
      round     <= '0;
      pattern   <= '0;
      guess     <= '0;
      correct   <= '0;
      incorrect <= '0;
      percent   <= '0;
    end else begin
      lfsr    <= {lfsr[PAT_W-2:0],
                  lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      st_sync <= {st_sync[1:0], key_start_n};
      sb_sync <= {sb_sync[1:0], key_submit_n};
      tmr     <= (state_nx != state) ? 32'd0 : tmr + 32'd1;

      if (state == ST_READ) pattern <= mem_rdata;
      if (state == ST_WAIT && submit_ev) guess <= sw_s2;

      if (div_start) begin
        if (hit) correct   <= correct + 7'd1;
        else     incorrect <= incorrect + 7'd1;
      end

      if (div_done) percent <= div_q;

      if (check_end && round != 4'(NUM_ROUNDS - 1))
        round <= round + 4'd1;

      if (state == ST_OVER && start_ev) begin
        round     <= '0;
        correct   <= '0;
        incorrect <= '0;
        percent   <= '0;
      end
    end
  end

  memory_percent_div u_div (
    .clk      (clock_50M),
    .rst_n    (resetn),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (tot_nx),
    .quotient (div_q),
    .done     (div_done)
  );

endmodule
